// File: rtl/lfcpnx_evn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lfcpnx_evn_pkg
// Purpose : Shared constants, RX state encoding and helper functions for the
//           LFCPNX evaluation-board demo block (trace record types, LFSR seed
//           and polynomial, baud divider calculation, LFSR step).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package lfcpnx_evn_pkg;

  // Trace record types, carried in trace_data[35:32]
  localparam logic [3:0] c_rec_tx     = 4'h1;
  localparam logic [3:0] c_rec_rx_ok  = 4'h2;
  localparam logic [3:0] c_rec_rx_err = 4'h3;

  localparam logic [31:0] c_lfsr_seed = 32'h0000_0001;
  localparam logic [31:0] c_lfsr_poly = 32'h8020_0003;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Cycles per UART bit, truncated
  function automatic int baud_div(input int clk, input int baud);
    return clk / baud;
  endfunction

  // Galois right-shift LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return cur[0] ? ((cur >> 1) ^ c_lfsr_poly) : (cur >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfcpnx_evn_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : lfcpnx_evn_uart_rx
// Purpose : 8N1 UART receiver: 2-flop synchronizer plus sampling FSM.
// Ports   : external_clock  in   clock (rising edge)
//           resetn          in   synchronous active-low reset
//           uart_rx         in   asynchronous receive line, idle high
//           rx_byte         out  last assembled byte (valid with strobes)
//           rx_ok           out  one-cycle strobe on the stop-sample cycle,
//                                stop bit read high
//           rx_frame_err    out  one-cycle strobe on the stop-sample cycle,
//                                stop bit read low
// Rev     : 1.0  initial release
// ============================================================================
module lfcpnx_evn_uart_rx
  import lfcpnx_evn_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       external_clock,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_ok,
  output logic       rx_frame_err
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_half = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(BAUD_DIV);

  logic             r_sync1, r_sync2;
  rx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;

  always_ff @(posedge external_clock) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // r_cnt is the number of cycles since the reference point of the current
  // state: the first synced-low cycle for START, the previous sample for
  // DATA/STOP. Samples therefore fall on r_cnt == half / full.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    rx_ok        = 1'b0;
    rx_frame_err = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = c_one;
        end
      end
      RX_START: begin
        if (r_cnt == c_half) begin
          if (r_sync2) begin
            w_state_nxt = RX_IDLE;        // glitch, not a start bit
          end else begin
            w_state_nxt = RX_DATA;
            w_cnt_nxt   = c_one;
            w_bit_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      RX_DATA: begin
        if (r_cnt == c_full) begin
          w_shift_nxt = {r_sync2, r_shift[7:1]};   // LSB arrives first
          w_cnt_nxt   = c_one;
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      RX_STOP: begin
        if (r_cnt == c_full) begin
          if (r_sync2) begin
            rx_ok       = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            rx_frame_err = 1'b1;
            w_state_nxt  = RX_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low (break) line must not look like a new start bit
        if (r_sync2) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_byte = r_shift;

endmodule
`default_nettype wire

// File: rtl/lfcpnx_evn.sv
`default_nettype none
// ============================================================================
// Module  : lfcpnx_evn
// Purpose : LFCPNX evaluation-board demo block. Streams a 32-bit Galois LFSR
//           sequence (low byte per frame) over an 8N1 UART transmitter,
//           receives 8N1 bytes, publishes every TX word and RX frame on a
//           36-bit trace port, and raises a sticky trap at end of run.
// Config  : `define LFCPNX_EVN_FRAME_TRAP_EN to also set trap on an RX
//           framing error.
// Ports   : external_clock  in   sole clock (rising edge)
//           resetn          in   synchronous active-low reset
//           uart_rx         in   UART receive line, asynchronous, idle high
//           uart_tx         out  UART transmit line, idle high
//           trace_data      out  [35:32] record type, [31:0] payload
//           trace_valid     out  one-cycle strobe qualifying trace_data
//           trap            out  sticky end-of-run / error flag
// Rev     : 1.0  initial release
// ============================================================================
module lfcpnx_evn
  import lfcpnx_evn_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TRACE_COUNT = 64
) (
  input  logic        external_clock,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [35:0] trace_data,
  output logic        trace_valid,
  output logic        trap
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);
  localparam int WORDS_W  = $clog2(TRACE_COUNT + 1);
  localparam logic [CNT_W-1:0]   c_div_last  = CNT_W'(BAUD_DIV - 1);
  localparam logic [WORDS_W-1:0] c_words_max = WORDS_W'(TRACE_COUNT);

  logic [7:0]         w_rx_byte;
  logic               w_rx_ok, w_rx_err, w_rx_rec;
  logic               w_tx_done, w_tx_load, w_frame_trap;

  logic               r_tx_busy;
  logic [CNT_W-1:0]   r_tx_cnt;
  logic [3:0]         r_tx_bit;     // 0 start, 1..8 data, 9 stop
  logic [7:0]         r_tx_shift;
  logic [31:0]        r_lfsr;
  logic [WORDS_W-1:0] r_tx_words;
  logic               r_uart_tx;
  logic [35:0]        r_trace_data;
  logic               r_trace_valid;
  logic               r_trap;

  lfcpnx_evn_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_rx (
    .external_clock (external_clock),
    .resetn         (resetn),
    .uart_rx        (uart_rx),
    .rx_byte        (w_rx_byte),
    .rx_ok          (w_rx_ok),
    .rx_frame_err   (w_rx_err)
  );

  assign w_rx_rec  = w_rx_ok | w_rx_err;

  // Last cycle of the stop bit; the next frame may load on this same edge
  assign w_tx_done = r_tx_busy && (r_tx_cnt == c_div_last) && (r_tx_bit == 4'd9);

  // An RX record owns the trace port this cycle, so the TX load slips by one
  assign w_tx_load = (!r_tx_busy || w_tx_done) && (r_tx_words != c_words_max)
                     && !r_trap && !w_rx_rec;

`ifdef LFCPNX_EVN_FRAME_TRAP_EN
  assign w_frame_trap = w_rx_err;
`else
  assign w_frame_trap = 1'b0;
`endif

  always_ff @(posedge external_clock) begin
    if (!resetn) begin
      r_tx_busy     <= 1'b0;
      r_tx_cnt      <= '0;
      r_tx_bit      <= '0;
      r_tx_shift    <= '0;
      r_lfsr        <= c_lfsr_seed;
      r_tx_words    <= '0;
      r_uart_tx     <= 1'b1;
      r_trace_data  <= '0;
      r_trace_valid <= 1'b0;
      r_trap        <= 1'b0;
    end else begin
      r_trace_valid <= 1'b0;
      if (w_rx_rec) begin
        r_trace_valid <= 1'b1;
        r_trace_data  <= {(w_rx_ok ? c_rec_rx_ok : c_rec_rx_err), 24'h0, w_rx_byte};
      end else if (w_tx_load) begin
        r_trace_valid <= 1'b1;
        r_trace_data  <= {c_rec_tx, r_lfsr};
      end

      if (w_tx_load) begin
        r_tx_busy  <= 1'b1;
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
        r_tx_shift <= r_lfsr[7:0];
        r_uart_tx  <= 1'b0;                 // start bit
        r_lfsr     <= lfsr_step(r_lfsr);
        r_tx_words <= r_tx_words + 1'b1;
      end else if (w_tx_done) begin
        r_tx_busy  <= 1'b0;
        r_uart_tx  <= 1'b1;
      end else if (r_tx_busy) begin
        if (r_tx_cnt == c_div_last) begin
          r_tx_cnt <= '0;
          r_tx_bit <= r_tx_bit + 4'd1;
          if (r_tx_bit == 4'd8) begin
            r_uart_tx <= 1'b1;              // stop bit
          end else begin
            r_uart_tx  <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end

      if ((w_tx_done && (r_tx_words == c_words_max)) || w_frame_trap) begin
        r_trap <= 1'b1;
      end
    end
  end

  assign uart_tx     = r_uart_tx;
  assign trace_data  = r_trace_data;
  assign trace_valid = r_trace_valid;
  assign trap        = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_lfcpnx_evn.sv
`default_nettype none
// ============================================================================
// Module  : tb_lfcpnx_evn
// Purpose : Directed self-checking bench for lfcpnx_evn (default clock and
//           baud, BAUD_DIV = 434, TRACE_COUNT reduced to 3).
// Rev     : 1.0  initial release
// ============================================================================
module tb_lfcpnx_evn;

  localparam int B = 434;

  logic        external_clock;
  logic        resetn;
  logic        uart_rx;
  logic        uart_tx;
  logic [35:0] trace_data;
  logic        trace_valid;
  logic        trap;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  lfcpnx_evn #(
    .CLK_FREQ    (50_000_000),
    .BAUD        (115200),
    .TRACE_COUNT (3)
  ) dut (
    .external_clock (external_clock),
    .resetn         (resetn),
    .uart_rx        (uart_rx),
    .uart_tx        (uart_tx),
    .trace_data     (trace_data),
    .trace_valid    (trace_valid),
    .trap           (trap)
  );

  initial external_clock = 1'b0;
  always #5 external_clock = ~external_clock;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // cyc = k means we sit 1 ns after the k-th edge with resetn high
  task automatic tick();
    @(posedge external_clock);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset(input logic rx_level);
    resetn  = 1'b0;
    uart_rx = rx_level;
    repeat (3) @(posedge external_clock);
    #1;
    chk("rst_uart_tx", {35'd0, uart_tx}, 36'd1);
    chk("rst_valid",   {35'd0, trace_valid}, 36'd0);
    chk("rst_data",    trace_data, 36'd0);
    chk("rst_trap",    {35'd0, trap}, 36'd0);
    resetn = 1'b1;
    cyc    = 0;
  endtask

  // Sample mid-bit of a TX frame whose start bit begins on cycle s
  task automatic decode_tx(input int s, input logic [7:0] exp, input string tag);
    logic [7:0] b;
    b = '0;
    goto(s + B/2);
    chk({tag, "_start"}, {35'd0, uart_tx}, 36'd0);
    for (int k = 0; k < 8; k++) begin
      goto(s + (k + 1)*B + B/2);
      b[k] = uart_tx;
    end
    chk({tag, "_byte"}, {28'd0, b}, {28'd0, exp});
    goto(s + 9*B + B/2);
    chk({tag, "_stop"}, {35'd0, uart_tx}, 36'd1);
  endtask

  // Drive an 8N1 frame whose start bit begins on cycle s; returns in stop bit
  task automatic send_rx(input int s, input logic [7:0] b);
    goto(s);
    uart_rx = 1'b0;
    for (int k = 0; k < 8; k++) begin
      goto(s + (k + 1)*B);
      uart_rx = b[k];
    end
    goto(s + 9*B);
    uart_rx = 1'b1;
  endtask

  initial begin
    int  n_rx;
    logic exp_brk_trap;
`ifdef LFCPNX_EVN_FRAME_TRAP_EN
    exp_brk_trap = 1'b1;
`else
    exp_brk_trap = 1'b0;
`endif
    resetn  = 1'b0;
    uart_rx = 1'b1;

    // ---- Run A: TX stream, LFSR order, hold, TX-count trap ----
    do_reset(1'b1);
    tick();
    chk("a_c1_valid", {35'd0, trace_valid}, 36'd1);
    chk("a_c1_data",  trace_data, 36'h1_0000_0001);
    chk("a_c1_tx",    {35'd0, uart_tx}, 36'd0);
    decode_tx(1, 8'h01, "a_f1");
    goto(4340);
    chk("a_hold_valid", {35'd0, trace_valid}, 36'd0);
    chk("a_hold_data",  trace_data, 36'h1_0000_0001);
    goto(4341);
    chk("a_rec2_valid", {35'd0, trace_valid}, 36'd1);
    chk("a_rec2_data",  trace_data, 36'h1_8020_0003);
    decode_tx(4341, 8'h03, "a_f2");
    goto(8681);
    chk("a_rec3_data",  trace_data, 36'h1_C030_0002);
    goto(13020);
    chk("a_trap_before", {35'd0, trap}, 36'd0);
    goto(13021);
    chk("a_trap_set",    {35'd0, trap}, 36'd1);
    goto(13022);
    chk("a_no_4th_load", {35'd0, trace_valid}, 36'd0);
    goto(13500);
    chk("a_idle_tx",     {35'd0, uart_tx}, 36'd1);
    chk("a_trap_sticky", {35'd0, trap}, 36'd1);

    // ---- Run B: received byte 0xA5 ----
    do_reset(1'b1);
    send_rx(100, 8'hA5);
    goto(4225);
    chk("b_pre_valid", {35'd0, trace_valid}, 36'd0);
    goto(4226);
    chk("b_rx_valid",  {35'd0, trace_valid}, 36'd1);
    chk("b_rx_data",   trace_data, 36'h2_0000_00A5);
    chk("b_trap",      {35'd0, trap}, 36'd0);

    // ---- Run C: RX stop sample on the TX reload cycle, then mid-frame reset ----
    do_reset(1'b1);
    send_rx(215, 8'h3C);
    goto(4340);
    chk("c_pre_valid", {35'd0, trace_valid}, 36'd0);
    goto(4341);
    chk("c_rx_first",  trace_data, 36'h2_0000_003C);
    chk("c_tx_idle",   {35'd0, uart_tx}, 36'd1);
    goto(4342);
    chk("c_tx_valid",  {35'd0, trace_valid}, 36'd1);
    chk("c_tx_second", trace_data, 36'h1_8020_0003);
    chk("c_tx_start",  {35'd0, uart_tx}, 36'd0);
    decode_tx(4342, 8'h03, "c_f2");
    goto(8682);
    chk("c_rec3_data", trace_data, 36'h1_C030_0002);
    goto(8800);
    chk("c_mid_low",   {35'd0, uart_tx}, 36'd0);
    resetn = 1'b0;
    @(posedge external_clock);
    #1;
    chk("c_abort_tx",  {35'd0, uart_tx}, 36'd1);
    chk("c_abort_val", {35'd0, trace_valid}, 36'd0);

    // ---- Run D: break line held low from reset ----
    do_reset(1'b0);
    goto(4125);
    chk("d_pre_valid", {35'd0, trace_valid}, 36'd0);
    goto(4126);
    chk("d_brk_valid", {35'd0, trace_valid}, 36'd1);
    chk("d_brk_data",  trace_data, 36'h3_0000_0000);
    chk("d_brk_trap",  {35'd0, trap}, {35'd0, exp_brk_trap});
    n_rx = 0;
    while (cyc < 6000) begin
      tick();
      if (trace_valid && trace_data[35:32] != 4'h1) n_rx++;
    end
    chk("d_no_retrig", 36'(n_rx), 36'd0);
    chk("d_trap_late", {35'd0, trap}, {35'd0, exp_brk_trap});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfcpnx_evn.md
# lfcpnx_evn

Top-level demo SoC block for the LFCPNX evaluation board. It streams a 32-bit Galois LFSR sequence out over an 8N1 UART and receives 8N1 bytes on the UART input. Every transmitted word and every received frame is published on a 36-bit trace port. A sticky `trap` signals end-of-run, which the simulation harness uses as its stop condition.

## Interface
- `CLK_FREQ`, 50_000_000: `external_clock` frequency in Hz.
- `BAUD`, 115200: UART bit rate. `BAUD_DIV = CLK_FREQ/BAUD`, truncated; 434 at defaults.
- `TRACE_COUNT`, 64: number of TX words before end-of-run trap.
- `external_clock`  in  1: sole clock; all logic on its rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `uart_rx`  in  1: UART receive line, asynchronous; idle high.
- `uart_tx`  out  1: UART transmit line; idle high.
- `trace_data`  out  36: `[35:32]` record type, `[31:0]` payload.
- `trace_valid`  out  1: one-cycle strobe qualifying `trace_data`.
- `trap`  out  1: sticky end-of-run / error flag.

## Operation
- **Record types:**
  - `4'h1` TX word; payload = LFSR value loaded.
  - `4'h2` RX byte OK; payload = `{24'h0, byte}`.
  - `4'h3` RX framing error; payload = `{24'h0, byte}`.
- **LFSR:**
  - Seed `32'h0000_0001`.
  - Step: if bit0 = 1, `next = (lfsr>>1) ^ 32'h8020_0003`; else `next = lfsr>>1`.
  - Steps once per TX load, after the load.
- **TX:**
  - When idle and fewer than `TRACE_COUNT` words have been sent, load `lfsr[7:0]` and emit a `4'h1` record the same cycle.
  - Frame: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly `BAUD_DIV` cycles.
  - Reload on the cycle after the stop bit ends, giving back-to-back frames every `10*BAUD_DIV` cycles.
- **RX:**
  - `uart_rx` passes through a 2-flop synchronizer. States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE→START when the synced line is low.
  - START: sample at `BAUD_DIV/2`. If high, return to IDLE (glitch). If low, go to DATA.
  - DATA: 8 samples, each `BAUD_DIV` apart, LSB first.
  - STOP: sample `BAUD_DIV` later. If 1, emit `4'h2` and go to IDLE. If 0, emit `4'h3` and go to WAIT_HIGH.
  - WAIT_HIGH→IDLE only once the synced line reads 1. This prevents a held-low (break) line from re-triggering.
- **Trap:**
  - Set on the cycle after the `TRACE_COUNT`-th TX frame's stop bit ends.
  - Set on an RX framing error when the configuration macro is defined (see Configuration).
  - Cleared only by reset. After trap, TX stays idle high; RX continues and still traces.
- **Simultaneous records:** RX record wins the cycle. A pending TX load is deferred one cycle, shifting that whole TX frame by one cycle.

## Timing
- Reset values: `uart_tx` = 1, `trace_valid` = 0, `trace_data` = 0, `trap` = 0. LFSR = seed, TX count = 0, RX in IDLE.
- First TX load and its `4'h1` record occur on the first clock edge with `resetn` high. `uart_tx` falls on that same registered edge.
- RX latency: the record is registered on the cycle after the stop sample. That is, with t0 = first synced-low cycle, t0 + `BAUD_DIV/2` + 9·`BAUD_DIV` + 1.
- `trace_data` holds its last value when `trace_valid` = 0.
- Reset asserted mid-frame aborts both UARTs immediately; `uart_tx` returns high on the next edge.

## Configuration
- `LFCPNX_EVN_FRAME_TRAP_EN` defined: an RX framing error sets `trap` on the same cycle as its `4'h3` record.
- Undefined: a framing error only emits the `4'h3` record. `trap` comes solely from TX count exhaustion.

## Structure
- Package `lfcpnx_evn_pkg` holds:
  - record-type localparams;
  - LFSR seed and polynomial;
  - RX state enum typedef;
  - a `baud_div(clk, baud)` function.
- Sub-module `lfcpnx_evn_uart_rx`: synchronizer plus RX FSM. Outputs byte, `ok` strobe and `frame_err` strobe.
- TX, LFSR, trace mux and trap logic live in the top.

## Test plan
- **Reset, defaults:** release `resetn` at cycle 0 → cycle 1 `trace_valid` with `trace_data` = `36'h1_0000_0001` and `uart_tx` low. Cycle 4341 next record = `36'h1_8020_0003`.
- **TX bits:** decode `uart_tx` at `BAUD_DIV` = 434 per bit → first frame byte `0x01`, second `0x03`. Stop bits high.
- **RX byte:** drive frame `0xA5`, `uart_rx` idle high → single record `36'h2_0000_00A5`. `trap` remains 0.
- **Break line, macro defined:** hold `uart_rx` = 0 from reset → one record `36'h3_0000_0000` and `trap` = 1 near cycle 4130. No further RX records while the line is low.
- **Break line, macro undefined:** same stimulus → `4'h3` record present, `trap` stays 0 until 64 TX frames are done (cycle ≈ 277,761).
- **Collision:** time an RX stop sample to land on a TX reload cycle → RX record first, TX record one cycle later. LFSR order is unchanged.
